// File: rtl/demux16_collector.sv
// demux16_collector: steers the upstream mux select and rebuilds the word.
// Define DEMUX_PARITY_EN to collect a trailing even-parity bit.
module demux16_collector #(
    parameter int IDX_W    = 4,
    parameter int LAST_IDX = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  bit_valid,
    input  logic                  f,
    output logic [IDX_W-1:0]      s,
    output logic                  busy,
    output logic [0:2**IDX_W-1]   w,
    output logic                  done,
    output logic                  parity_err
);

    localparam int W = 2**IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT
`ifdef DEMUX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] s_nxt;
    logic [0:W-1]     shadow, shadow_nxt;
    logic [0:W-1]     w_nxt;
    logic             done_nxt;
    logic             last_bit;

`ifdef DEMUX_PARITY_EN
    logic perr, perr_nxt;
`endif

    assign last_bit = (s == IDX_W'(LAST_IDX));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        s_nxt      = s;
        shadow_nxt = shadow;
        w_nxt      = w;
        done_nxt   = 1'b0;
`ifdef DEMUX_PARITY_EN
        perr_nxt   = perr;
`endif
        unique case (state)
            IDLE: begin
                s_nxt = '0;
                if (start && !abort) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                // abort outranks even the final valid bit
                if (abort) begin
                    state_nxt = IDLE;
                    s_nxt     = '0;
                end else if (bit_valid) begin
                    shadow_nxt[s] = f;
                    s_nxt         = s + IDX_W'(1);
                    if (last_bit) begin
                        s_nxt = '0;
`ifdef DEMUX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        w_nxt     = shadow_nxt;
                        done_nxt  = 1'b1;
`endif
                    end
                end
            end
`ifdef DEMUX_PARITY_EN
            PARITY: begin
                if (abort) begin
                    state_nxt = IDLE;
                    s_nxt     = '0;
                end else if (bit_valid) begin
                    state_nxt = IDLE;
                    w_nxt     = shadow;
                    done_nxt  = 1'b1;
                    perr_nxt  = ^{shadow, f};
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                s_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            shadow <= '0;
            w      <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            s      <= s_nxt;
            shadow <= shadow_nxt;
            w      <= w_nxt;
            done   <= done_nxt;
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_nxt;
        end
    end

    assign parity_err = perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux16_collector.sv
// tb_demux16_collector: directed stimulus checked against a word-level model.
// Build with DEMUX_PARITY_EN to exercise the trailing parity bit.
module tb_demux16_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bit_valid = 1'b0;
    logic        f = 1'b0;
    logic [3:0]  s;
    logic        busy;
    logic [0:15] w;
    logic        done;
    logic        parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

`ifdef DEMUX_PARITY_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    localparam logic [0:15] WORD_A = 16'b1010_1100_1111_0001;

    demux16_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .f          (f),
        .s          (s),
        .busy       (busy),
        .w          (w),
        .done       (done),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 idle, 1 gathering bits, 2 awaiting parity bit.
    int          m_phase;
    int          m_idx;
    logic [0:15] m_bits;
    logic [0:15] m_w;
    logic        m_done;
    logic        m_perr;

    function automatic logic [0:15] with_bit(input logic [0:15] b,
                                             input int i, input logic v);
        b[i] = v;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_idx   <= 0;
            m_bits  <= '0;
            m_w     <= '0;
            m_done  <= 1'b0;
            m_perr  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_phase == 0) begin
                if (start && !abort) begin
                    m_phase <= 1;
                    m_idx   <= 0;
                end
            end else if (abort) begin
                m_phase <= 0;
                m_idx   <= 0;
            end else if (bit_valid && m_phase == 1) begin
                m_bits[m_idx] <= f;
                if (m_idx == 15) begin
                    m_idx <= 0;
`ifdef DEMUX_PARITY_EN
                    m_phase <= 2;
`else
                    m_phase <= 0;
                    m_w     <= with_bit(m_bits, 15, f);
                    m_done  <= 1'b1;
`endif
                end else begin
                    m_idx <= m_idx + 1;
                end
            end else if (bit_valid && m_phase == 2) begin
                m_phase <= 0;
                m_w     <= m_bits;
                m_done  <= 1'b1;
                m_perr  <= 1'((($countones(m_bits) + int'(f)) % 2));
            end
        end
    end

    always @(negedge clk) begin
        chk("s", 32'(s), 32'(m_idx));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("w", 32'(w), 32'(m_w));
        chk("done", 32'(done), 32'(m_done));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
    end

    // Drives bits from index 0; stops before stop_at, stalls 3 cycles
    // before stall_a/stall_b, pulses start with bit start_at.
    task automatic feed(input logic [0:15] word, input int stop_at,
                        input int stall_a, input int stall_b,
                        input int start_at, input logic par_flip);
        for (int i = 0; i < 16; i++) begin
            if (i == stop_at) begin
                bit_valid = 1'b0;
                start     = 1'b0;
                return;
            end
            if (i == stall_a || i == stall_b) begin
                bit_valid = 1'b0;
                start     = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_s", 32'(s), 32'(i));
                end
            end
            bit_valid = 1'b1;
            f         = word[i];
            start     = (i == start_at);
            @(negedge clk);
        end
`ifdef DEMUX_PARITY_EN
        start     = 1'b0;
        bit_valid = 1'b1;
        f         = (^word) ^ par_flip;
        @(negedge clk);
`else
        if (par_flip) $display("note: parity bit ignored in this build");
`endif
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic kick(output int k);
        start = 1'b1;
        k     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        #3;
        chk("reset_w", 32'(w), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        #19 rst_n = 1'b1;
        @(negedge clk);

        // plain collection
        kick(k);
        feed(WORD_A, 99, 99, 99, 99, 1'b0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_lat", 32'(cyc - k), 32'(LAT));
        chk("t1_w", 32'(w), 32'hACF1);
        chk("t1_perr", 32'(parity_err), 32'h0);
        @(negedge clk);
        chk("t1_done_low", 32'(done), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);

        // stalls at s=5 and s=13
        kick(k);
        feed(WORD_A, 99, 5, 13, 99, 1'b0);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_lat", 32'(cyc - k), 32'(LAT + 6));
        chk("t2_w", 32'(w), 32'hACF1);
        @(negedge clk);

        // abort mid-word and on the final bit
        kick(k);
        feed(16'hFFFF, 99, 99, 99, 99, 1'b0);
        chk("t3_w_ff", 32'(w), 32'hFFFF);
        kick(k);
        feed(16'h0000, 7, 99, 99, 99, 1'b0);
        chk("t3_s7", 32'(s), 32'h7);
        abort     = 1'b1;
        bit_valid = 1'b1;
        f         = 1'b0;
        @(negedge clk);
        abort     = 1'b0;
        bit_valid = 1'b0;
        chk("t3_abort_busy", 32'(busy), 32'h0);
        chk("t3_abort_s", 32'(s), 32'h0);
        chk("t3_abort_done", 32'(done), 32'h0);
        chk("t3_abort_w", 32'(w), 32'hFFFF);
        kick(k);
        feed(16'h0000, 15, 99, 99, 99, 1'b0);
        abort     = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        bit_valid = 1'b0;
        chk("t3_last_done", 32'(done), 32'h0);
        chk("t3_last_w", 32'(w), 32'hFFFF);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_idle_busy", 32'(busy), 32'h0);

        // asynchronous reset mid-collection
        kick(k);
        feed(16'h0000, 9, 99, 99, 99, 1'b0);
        chk("t4_s9", 32'(s), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_w", 32'(w), 32'h0);
        chk("t4_rst_s", 32'(s), 32'h0);
        chk("t4_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        kick(k);
        feed(16'h00F0, 99, 99, 99, 99, 1'b0);
        chk("t4_w", 32'(w), 32'h00F0);

        // start while busy is ignored; start during done restarts
        @(negedge clk);
        kick(k);
        feed(WORD_A, 99, 99, 99, 4, 1'b0);
        chk("t5_lat", 32'(cyc - k), 32'(LAT));
        chk("t5_done", 32'(done), 32'h1);
        kick(k);
        chk("t5_busy", 32'(busy), 32'h1);
        chk("t5_s", 32'(s), 32'h0);
        feed(16'h1234, 99, 99, 99, 99, 1'b0);
        chk("t5_w", 32'(w), 32'h1234);
        chk("t5_lat2", 32'(cyc - k), 32'(LAT));

`ifdef DEMUX_PARITY_EN
        @(negedge clk);
        kick(k);
        feed(WORD_A, 99, 99, 99, 99, 1'b1);
        chk("t6_perr_bad", 32'(parity_err), 32'h1);
        chk("t6_lat", 32'(cyc - k), 32'd18);
        @(negedge clk);
        chk("t6_perr_hold", 32'(parity_err), 32'h1);
        kick(k);
        feed(WORD_A, 99, 99, 99, 99, 1'b0);
        chk("t6_perr_ok", 32'(parity_err), 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux16_collector.md
Name: demux16_collector

Overview:
- Receive-side counterpart of the 16-to-1 select-mux path.
- Drives the 4-bit select index `s` to the upstream mux and samples the returned serial bit `f` on each valid cycle.
- Rebuilds the 16-bit word `w[0:15]` with `w[s] = f`, then presents it with a one-cycle done pulse.
- Sits between a mux-based serializer and downstream parallel consumers.

Parameters:
- IDX_W, 4, select index width; word width is 2**IDX_W = 16.
- LAST_IDX, 15, final index collected before completion.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a collection; sampled only in IDLE.
- abort  input  1  abandon the collection in progress; return to IDLE.
- bit_valid  input  1  `f` is valid for the current `s` this cycle.
- f  input  1  serial bit from the upstream mux output.
- s  output  4  select index driven to the upstream mux.
- busy  output  1  high in COLLECT (and PARITY when enabled).
- w  output  16 [0:15]  last completed word; `w[0]` corresponds to `s=0`.
- done  output  1  one-cycle pulse when `w` is updated.
- parity_err  output  1  only with DEMUX_PARITY_EN; otherwise tied to 0.

Behaviour:
- Reset (async, `rst_n=0`):
  - State = IDLE.
  - `s=0`, `busy=0`, `done=0`, `parity_err=0`.
  - `w=16'h0000`, shadow register = 0.
  - A reset mid-collection discards partial data immediately.
- States: IDLE, COLLECT, PARITY (only when the macro is defined).
- IDLE:
  - `s` held at 0; `busy=0`.
  - `start=1` -> COLLECT next cycle with `s=0`.
- COLLECT:
  - `bit_valid=1`: `shadow[s] <= f`, `s <= s+1`.
  - `bit_valid=0`: stall; `s` and shadow held, no timeout.
  - When `bit_valid=1` and `s==LAST_IDX`:
    - `w <= {shadow[0:14], f}`, `done=1` next cycle, state -> IDLE, `s` wraps to 0.
    - With the macro defined, go to PARITY instead (see Optional Feature).
- `start` while busy: ignored, no restart.
- `abort=1` in COLLECT/PARITY:
  - -> IDLE next cycle, `s=0`.
  - `w` is unchanged and no `done` pulse.
  - `abort` takes priority over a simultaneous final valid bit.
- `abort` in IDLE: no effect. `start` and `abort` together in IDLE: stay IDLE.
- Timing:
  - Minimum latency from `start` to `done` = 17 cycles (1 to enter COLLECT + 16 valid bits); `done` is asserted the cycle after the 16th bit.
  - `done` is high for exactly one cycle.
  - `w` holds its value until the next completion.
  - A new `start` is accepted in the cycle `done` is high (state is IDLE).
- `s` is registered; the upstream mux sees the new index the cycle after each accepted bit.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - After index 15, enter PARITY.
  - The next `bit_valid` cycle samples `f` as an even-parity bit.
  - `parity_err <= ^{word, f}`.
  - `w` is updated and `done` pulses in the same cycle as `parity_err`; `parity_err` holds until the next completion or reset.
  - Latency becomes 18 cycles.
- Undefined:
  - No PARITY state; `parity_err` is constant 0.

Test Plan:
- Reset then `start`; feed `f` for `s`=0..15 = 1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,1 with `bit_valid` always high -> `done` one cycle, `w=16'b1010_1100_1111_0001`, `s` sequence 0..15 then 0, `busy` low after.
- Same word with `bit_valid` low for 3 cycles at `s=5` and `s=13` -> `s` holds 5 and 13 during stalls; same `w`; `done` at cycle 23.
- Collect `16'hFFFF`, then `abort` at `s=7` during a `16'h0000` collection -> `w` remains `16'hFFFF`, no `done`, `s=0`.
- `rst_n` low at `s=9` mid-collection -> `w=0`, `s=0`, `busy=0` immediately; next full collection of `16'h00F0` -> `w=16'h00F0`.
- `start` pulsed at `s=4` while busy -> ignored; `start` held during the `done` cycle -> next collection begins the following cycle.
- DEMUX_PARITY_EN: word `16'b1010_1100_1111_0001` (9 ones) with parity bit 1 -> `parity_err=0`; parity bit 0 -> `parity_err=1`, `done` at cycle 18.
